line_mem_responder: RTL and testbench

Multi-cycle backing-memory responder for the cache-fill protocol: the memory end of the cache/memory handshake driven by the cache miss controller. Accepts one line-granular read or write request at a time, holds it for a fixed programmable latency, then completes it with a one-cycle `rdy` pulse. It replaces the behavioural unified memory model behind the I-cache and future D-cache fill controllers.

---
 rtl/line_mem_if.sv | 16 +
 rtl/line_mem_responder.sv | 84 ++++++++
 tb/tb_line_mem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/line_mem_if.sv
// Cache-fill handshake between a miss controller (master) and the line memory (slave).
interface line_mem_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LINE_W = 64
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rd_data;
  logic              rdy;
  logic              busy;

  modport master (output addr, re, we, wdata, input rd_data, rdy, busy);
  modport slave  (input addr, re, we, wdata, output rd_data, rdy, busy);
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder: one request at a time, rdy pulse on completion.
// Write path compiled in only when LINE_MEM_WRITE_EN is defined; otherwise read-only.
module line_mem_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned LATENCY = 4
) (
  input logic        clk,
  input logic        rst_n,
  line_mem_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_wr;
  logic              rdy_q;
  logic [LINE_W-1:0] rd_data_q;
  logic              we_eff;
  logic              accept;
  logic              access;

  logic [LINE_W-1:0] mem [2**ADDR_W];

`ifdef LINE_MEM_WRITE_EN
  assign we_eff = bus.we;
`else
  // Read-only build: a write request is invisible, so re&we degrades to a plain read.
  assign we_eff = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.re || we_eff) state_nx = WAIT;
      WAIT: if (cnt == 4'd0)      state_nx = DONE;
      DONE:                       state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && (bus.re || we_eff);
    access = (state == WAIT) && (cnt == 4'd0);
  end

  assign bus.busy    = (state != IDLE);
  assign bus.rdy     = rdy_q;
  assign bus.rd_data = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr     <= 1'b0;
      rdy_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        op_wr   <= we_eff;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      rdy_q <= access;
      if (access && !op_wr) rd_data_q <= mem[addr_q];
    end
  end

  // Array is deliberately outside the reset domain; reset forces IDLE so access is blocked.
  always_ff @(posedge clk) begin
    if (access && op_wr) mem[addr_q] <= wdata_q;
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder at LATENCY=4 and LATENCY=1 against an array model.
module tb_line_mem_responder;
  localparam int unsigned AW    = 14;
  localparam int unsigned LW    = 64;
  localparam int unsigned DEPTH = 2**AW;

  logic clk;
  logic rst_n;

  line_mem_if #(.ADDR_W(AW), .LINE_W(LW)) bus0 ();
  line_mem_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

  line_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  line_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [AW-1:0] addr_d  [2];
  logic          re_d    [2];
  logic          we_d    [2];
  logic [LW-1:0] wdata_d [2];
  logic          rdy_o   [2];
  logic          busy_o  [2];
  logic [LW-1:0] rd_o    [2];

  assign bus0.addr = addr_d[0];  assign bus0.re = re_d[0];
  assign bus0.we   = we_d[0];    assign bus0.wdata = wdata_d[0];
  assign bus1.addr = addr_d[1];  assign bus1.re = re_d[1];
  assign bus1.we   = we_d[1];    assign bus1.wdata = wdata_d[1];
  assign rdy_o[0]  = bus0.rdy;   assign busy_o[0] = bus0.busy;  assign rd_o[0] = bus0.rd_data;
  assign rdy_o[1]  = bus1.rdy;   assign busy_o[1] = bus1.busy;  assign rd_o[1] = bus1.rd_data;

  // Reference model: line contents and last returned read per instance.
  logic [LW-1:0] mem_m [2][DEPTH];
  logic [LW-1:0] rd_m  [2];
  int unsigned   lat_k [2];

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_accepts(input bit r, input bit w);
`ifdef LINE_MEM_WRITE_EN
    return r | w;
`else
    return r;
`endif
  endfunction

  function automatic bit model_is_write(input bit w);
`ifdef LINE_MEM_WRITE_EN
    return w;
`else
    return 1'b0;
`endif
  endfunction

  // One request on instance k; rst_after>0 pulses reset just after that many edges past E0.
  task automatic do_req(input int k, input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd, input int rst_after);
    bit acc, wr;
    int unsigned L;
    acc = model_accepts(r, w);
    wr  = model_is_write(w);
    L   = lat_k[k];
    @(negedge clk);
    addr_d[k] = a; wdata_d[k] = wd; re_d[k] = r; we_d[k] = w;
    @(posedge clk); #1;
    check("busy_at_accept", 64'(busy_o[k]), 64'(acc));
    for (int i = 1; i <= int'(L) + 1; i++) begin
      addr_d[k]  = AW'($urandom);
      wdata_d[k] = {$urandom, $urandom};
      @(posedge clk); #1;
      if (i == rst_after) begin
        rst_n = 1'b0;
        #1;
        check("rdy_in_reset", 64'(rdy_o[k]), 64'd0);
        check("busy_in_reset", 64'(busy_o[k]), 64'd0);
        check("rd_data_in_reset", rd_o[k], 64'd0);
        rd_m[0] = '0; rd_m[1] = '0;
        re_d[k] = 1'b0; we_d[k] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("rdy", 64'(rdy_o[k]), 64'(acc && (i == int'(L))));
      check("busy", 64'(busy_o[k]), 64'(acc && (i <= int'(L))));
      if (i == int'(L)) begin
        if (acc) begin
          if (wr) mem_m[k][a] = wd;
          else    rd_m[k]     = mem_m[k][a];
        end
        check("rd_data", rd_o[k], rd_m[k]);
        re_d[k] = 1'b0; we_d[k] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] v;
    int op, ra;
    n_vec = 0; n_err = 0;
    lat_k[0] = 4; lat_k[1] = 1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr_d[k] = '0; re_d[k] = 1'b0; we_d[k] = 1'b0; wdata_d[k] = '0; rd_m[k] = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = {$urandom, $urandom}; dut0.mem[i] = v; mem_m[0][i] = v;
      v = {$urandom, $urandom}; dut1.mem[i] = v; mem_m[1][i] = v;
    end
    dut0.mem[14'h0010] = 64'hA001_B002_C003_D004; mem_m[0][14'h0010] = 64'hA001_B002_C003_D004;
    dut1.mem[14'h0010] = 64'hA001_B002_C003_D004; mem_m[1][14'h0010] = 64'hA001_B002_C003_D004;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_rdy", 64'(rdy_o[k]), 64'd0);
      check("reset_busy", 64'(busy_o[k]), 64'd0);
      check("reset_rd_data", rd_o[k], 64'd0);
    end

    do_req(0, 1'b1, 1'b0, 14'h0010, '0, 0);
    check("read_0010_const", rd_o[0], 64'hA001_B002_C003_D004);
    do_req(0, 1'b0, 1'b1, 14'h3FFF, 64'h1234_5678_9ABC_DEF0, 0);
    do_req(0, 1'b1, 1'b0, 14'h3FFF, '0, 0);
`ifdef LINE_MEM_WRITE_EN
    check("read_after_write_const", rd_o[0], 64'h1234_5678_9ABC_DEF0);
`endif
    do_req(0, 1'b1, 1'b1, 14'h0005, 64'hFFFF_0000_FFFF_0000, 0);
    do_req(0, 1'b1, 1'b0, 14'h0005, '0, 0);
    do_req(0, 1'b0, 1'b1, 14'h0020, {$urandom, $urandom}, 2);
    do_req(0, 1'b1, 1'b0, 14'h0020, '0, 0);
    do_req(1, 1'b1, 1'b0, 14'h0010, '0, 0);
    check("lat1_read_const", rd_o[1], 64'hA001_B002_C003_D004);
    do_req(1, 1'b1, 1'b1, 14'h0005, 64'hFFFF_0000_FFFF_0000, 0);
    do_req(1, 1'b1, 1'b0, 14'h0005, '0, 0);

    for (int n = 0; n < 120; n++) begin
      int k;
      k  = n % 2;
      op = int'($urandom_range(0, 3));
      ra = 0;
      if (lat_k[k] > 1 && $urandom_range(0, 15) == 0)
        ra = int'($urandom_range(1, lat_k[k] - 1));
      do_req(k, (op == 0 || op == 1 || op == 3), (op == 2 || op == 3),
             AW'($urandom_range(0, 63)), {$urandom, $urandom}, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
